// File: rtl/rca_pipe_nbit.sv
// ---------------------------------------------------------------------------
// rca_pipe_nbit
//   Pipelined ripple-carry adder/subtractor. The N-bit operation is cut into
//   STAGES chunks of W = N/STAGES bits; each pipeline stage ripples one chunk
//   and registers the chunk carry for the next stage, so the critical path is
//   a single W-bit ripple. One operation per cycle under valid/ready.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high
//   i_valid  input operation valid
//   o_ready  operation accepted this cycle when i_valid & o_ready
//   i_a      operand A            [N-1:0]
//   i_b      operand B            [N-1:0]
//   i_c      carry-in (add) / borrow-in (sub)
//   i_sub    0: A+B+c   1: A-B-c
//   o_valid  result valid
//   i_ready  downstream accepts result
//   o_s      sum/difference       [N-1:0]
//   o_c      carry out of bit N-1 (sub: 1 = no borrow)
//   o_ovf    two's-complement signed overflow
// ---------------------------------------------------------------------------
module rca_pipe_nbit #(
  parameter int N      = 64,
  parameter int STAGES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_s,
  output logic         o_c,
  output logic         o_ovf
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  if (N % STAGES != 0) begin : g_bad_split
    $error("rca_pipe_nbit: N must be a multiple of STAGES");
  end

  // One W-bit ripple chunk: returns {carry_out, sum}.
  function automatic logic [W:0] chunk_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Stage k registers: operands still to be added (upper chunks), partial
  // sum (lower chunks done), carry out of chunk k, valid.
  logic [N-1:0] a_p   [STAGES];
  logic [N-1:0] b_p   [STAGES];
  logic [N-1:0] s_p   [STAGES];
  logic         c_p   [STAGES];
  logic         vld_p [STAGES];
  logic         ovf_p;

  // Stage inputs (from entry or previous stage) and stage results.
  logic [N-1:0] a_in  [STAGES];
  logic [N-1:0] b_in  [STAGES];
  logic [N-1:0] s_in  [STAGES];
  logic         c_in  [STAGES];
  logic         v_in  [STAGES];
  logic [N-1:0] s_nxt [STAGES];
  logic         c_nxt [STAGES];
  logic [W:0]   sw;
  logic         ovf_nxt;
  logic         en;

  // Whole pipe advances together; it only holds when the head result is
  // waiting on a downstream that is not ready.
  assign en      = ~vld_p[L] | i_ready;
  assign o_ready = en;

  always_comb begin
    sw = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Subtraction as A + ~B + ~borrow.
        a_in[k] = i_a;
        b_in[k] = i_sub ? ~i_b : i_b;
        c_in[k] = i_sub ? ~i_c : i_c;
        s_in[k] = '0;
        v_in[k] = i_valid;
      end else begin
        a_in[k] = a_p[k-1];
        b_in[k] = b_p[k-1];
        c_in[k] = c_p[k-1];
        s_in[k] = s_p[k-1];
        v_in[k] = vld_p[k-1];
      end
      sw                   = chunk_add(a_in[k][k*W +: W], b_in[k][k*W +: W], c_in[k]);
      s_nxt[k]             = s_in[k];
      s_nxt[k][k*W +: W]   = sw[W-1:0];
      c_nxt[k]             = sw[W];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands;
    // overflow is that carry XOR the carry out of the MSB.
    ovf_nxt = (s_nxt[L][N-1] ^ a_in[L][N-1] ^ b_in[L][N-1]) ^ c_nxt[L];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        s_p[k]   <= '0;
        c_p[k]   <= 1'b0;
        vld_p[k] <= 1'b0;
      end
      ovf_p <= 1'b0;
    end else if (en) begin
      // --- stage k boundary: chunk k result and carry registered ---
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= a_in[k];
        b_p[k]   <= b_in[k];
        s_p[k]   <= s_nxt[k];
        c_p[k]   <= c_nxt[k];
        vld_p[k] <= v_in[k];
      end
      ovf_p <= ovf_nxt;
    end
  end

  assign o_valid = vld_p[L];
  assign o_s     = s_p[L];
  assign o_c     = c_p[L];
  assign o_ovf   = ovf_p;

endmodule
